imm_gen_pipe: RTL and testbench
===============================

Name: imm_gen_pipe

Overview:
Pipelined, parametrised successor to the combinational RV32I immediate generator. Accepts an instruction and its PC over a valid/ready handshake, then classifies the instruction format and builds the sign-extended XLEN-wide immediate. It also computes the PC-relative target (pc + imm) and counts illegal opcodes. Sits between fetch and the decode/execute boundary of the datapath, with a one-entry skid buffer so back-pressure never drops an instruction.

Parameters:
XLEN, 32, datapath width; legal values are 32 or 64. Controls the width of the immediate, PC and target.
CNT_W, 16, width of the saturating illegal-opcode counter.

Ports:
clk  input  1  clock; all state updates on the rising edge
rst  input  1  synchronous, active-high reset
in_valid  input  1  in_instr/in_pc are valid
in_ready  output  1  block can accept an input this cycle
in_instr  input  32  instruction word
in_pc  input  XLEN  PC of in_instr
out_valid  output  1  output fields are valid
out_ready  input  1  consumer accepts the output
out_imm  output  XLEN  sign-extended immediate
out_fmt  output  3  format: 0=R, 1=I, 2=S, 3=B, 4=U, 5=J, 6=Z, 7=illegal
out_target  output  XLEN  out_pc + out_imm, modulo 2^XLEN
out_illegal  output  1  1 when out_fmt==7
illegal_cnt  output  CNT_W  number of accepted illegal instructions

Behaviour:
- Handshakes:
  - Input transfer when in_valid && in_ready.
  - Output transfer when out_valid && out_ready.
  - in_ready = !skid_full. It is registered and depends on no input combinationally.
- Decode (combinational, on in_instr[6:0]):
  - I: 0010011, 0000011, 1100111, 0001111, 1110011
  - S: 0100011
  - B: 1100011
  - U: 0110111, 0010111
  - J: 1101111
  - R: 0110011
  - Any other opcode is illegal.
- Immediate construction:
  - I: sext(instr[31:20])
  - S: sext({instr[31:25], instr[11:7]})
  - B: sext({instr[31], instr[7], instr[30:25], instr[11:8], 1'b0})
  - U: sext({instr[31:12], 12'b0}); with XLEN=64, bits 63:32 copy instr[31].
  - J: sext({instr[31], instr[19:12], instr[20], instr[30:21], 1'b0})
  - R and illegal: out_imm = 0.
  - Sign extension always replicates instr[31] to XLEN.
- Target: out_target = pc + imm, truncated to XLEN. Wrap-around is silent.
- Pipeline:
  - Output register (OR) plus one skid entry (SK). Latency is 1 cycle from input accept to out_valid.
  - Throughput is 1 per cycle while out_ready=1.
- State machine {EMPTY, ONE, TWO}:
  - EMPTY → ONE on input accept: OR loads.
  - ONE with accept and no output transfer → TWO: SK loads, in_ready drops next cycle.
  - ONE with accept and output transfer → stays ONE: OR reloads from input.
  - ONE with output transfer only → EMPTY.
  - TWO with output transfer → ONE: OR ← SK.
  - TWO: no input is accepted.
  - Order is strictly preserved.
- Outputs are held stable while out_valid && !out_ready.
- illegal_cnt:
  - Increments by 1 on input accept of an illegal instruction.
  - Saturates at 2^CNT_W-1 and does not wrap.
- Reset (any cycle, including mid-transfer):
  - State becomes EMPTY and in-flight entries are discarded.
  - out_valid=0, in_ready=1, out_imm=0, out_fmt=0, out_target=0, out_illegal=0, illegal_cnt=0.
  - Inputs are ignored during the reset cycle.

Optional Feature:
Macro IMM_GEN_ZIMM_EN.
- Defined: opcode 1110011 with instr[14]=1 (CSRRWI/CSRRSI/CSRRCI) gives out_fmt=6 and out_imm = zero-extended instr[19:15].
- Undefined: these instructions decode as I format with sext(instr[31:20]), and value 6 is never produced.

Test Plan:
1. Reset, then one input each cycle with out_ready=1, XLEN=32, in_pc=0x100. Each output appears 1 cycle after accept:
   - 0x00500093 → imm=0x5, fmt=1, target=0x105
   - 0x00A12023 → imm=0x0, fmt=2
   - 0x00208663 → imm=0xC, fmt=3, target=0x10C
   - 0x004000EF → imm=0x4, fmt=5, target=0x104
2. Sign extension:
   - 0xFFF00093, pc=0x0 → imm=0xFFFFFFFF, target=0xFFFFFFFF.
   - With XLEN=64 → imm=0xFFFFFFFFFFFFFFFF.
   - 0x800000B7 with XLEN=64 → imm=0xFFFFFFFF80000000.
3. Back-pressure:
   - Hold out_ready=0 and push 3 instructions back-to-back. in_ready falls after the 2nd accept and the 3rd is held.
   - Release out_ready. Outputs arrive in order with no loss or duplication, and OR stays stable while stalled.
4. Illegal opcodes:
   - 0x0000007F → fmt=7, out_illegal=1, imm=0, illegal_cnt=1.
   - With CNT_W=2, after 5 illegal accepts illegal_cnt=3 (saturated).
5. Reset mid-operation: assert rst while in state TWO. Next cycle out_valid=0, in_ready=1, illegal_cnt=0, and the two entries are never emitted.
6. IMM_GEN_ZIMM_EN: 0x0002D073 (CSRRWI x0, 0, 5) → fmt=6, imm=0x5 when defined; fmt=1, imm=0x0 when undefined.

Source files
------------

// File: rtl/imm_gen_pipe.sv
// imm_gen_pipe: pipelined RV32I immediate generator with PC-relative target and a skid buffer.
// Optional macro IMM_GEN_ZIMM_EN adds the CSR zimm format (fmt 6).
module imm_gen_pipe #(
   parameter int XLEN  = 32,
   parameter int CNT_W = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [31:0]      in_instr,
   input  logic [XLEN-1:0]  in_pc,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [XLEN-1:0]  out_imm,
   output logic [2:0]       out_fmt,
   output logic [XLEN-1:0]  out_target,
   output logic             out_illegal,
   output logic [CNT_W-1:0] illegal_cnt
);
   typedef enum logic [1:0] {EMPTY, ONE, TWO} state_t;
   state_t            r_st;
   logic              r_rdy, r_vld;
   logic [XLEN-1:0]   r_imm, r_tgt, r_sk_imm, r_sk_tgt;
   logic [2:0]        r_fmt, r_sk_fmt;
   logic [CNT_W-1:0]  r_cnt;
   logic [2:0]        w_fmt;
   logic [31:0]       w_i32;
   logic [XLEN-1:0]   w_imm, w_tgt;
   logic              w_acc, w_otx;
   always_comb begin
      w_fmt = 3'd7;
      case (in_instr[6:0])
         7'b0010011, 7'b0000011, 7'b1100111, 7'b0001111, 7'b1110011: w_fmt = 3'd1;
         7'b0100011: w_fmt = 3'd2;
         7'b1100011: w_fmt = 3'd3;
         7'b0110111, 7'b0010111: w_fmt = 3'd4;
         7'b1101111: w_fmt = 3'd5;
         7'b0110011: w_fmt = 3'd0;
         default: w_fmt = 3'd7;
      endcase
`ifdef IMM_GEN_ZIMM_EN
      if (in_instr[6:0] == 7'b1110011 && in_instr[14]) w_fmt = 3'd6;
`endif
      case (w_fmt)
         3'd1: w_i32 = {{20{in_instr[31]}}, in_instr[31:20]};
         3'd2: w_i32 = {{20{in_instr[31]}}, in_instr[31:25], in_instr[11:7]};
         3'd3: w_i32 = {{20{in_instr[31]}}, in_instr[7], in_instr[30:25], in_instr[11:8], 1'b0};
         3'd4: w_i32 = {in_instr[31:12], 12'b0};
         3'd5: w_i32 = {{12{in_instr[31]}}, in_instr[19:12], in_instr[20], in_instr[30:21], 1'b0};
         3'd6: w_i32 = {27'b0, in_instr[19:15]};
         default: w_i32 = 32'b0;
      endcase
   end
   // bit 31 of w_i32 is the instruction sign for every signed format, so a signed cast widens correctly
   assign w_imm       = XLEN'($signed(w_i32));
   assign w_tgt       = in_pc + w_imm;
   assign w_acc       = in_valid && r_rdy;
   assign w_otx       = r_vld && out_ready;
   assign in_ready    = r_rdy;
   assign out_valid   = r_vld;
   assign out_imm     = r_imm;
   assign out_fmt     = r_fmt;
   assign out_target  = r_tgt;
   assign out_illegal = r_fmt == 3'd7;
   assign illegal_cnt = r_cnt;
   always_ff @(posedge clk) begin
      if (rst) begin
         r_st     <= EMPTY;
         r_rdy    <= 1'b1;
         r_vld    <= 1'b0;
         r_imm    <= '0;
         r_fmt    <= '0;
         r_tgt    <= '0;
         r_sk_imm <= '0;
         r_sk_fmt <= '0;
         r_sk_tgt <= '0;
         r_cnt    <= '0;
      end else begin
         if (w_acc && w_fmt == 3'd7 && r_cnt != '1) r_cnt <= r_cnt + CNT_W'(1);
         case (r_st)
            EMPTY: if (w_acc) begin
               r_imm <= w_imm;
               r_fmt <= w_fmt;
               r_tgt <= w_tgt;
               r_vld <= 1'b1;
               r_st  <= ONE;
            end
            ONE: if (w_acc && w_otx) begin
               r_imm <= w_imm;
               r_fmt <= w_fmt;
               r_tgt <= w_tgt;
            end else if (w_acc) begin
               r_sk_imm <= w_imm;
               r_sk_fmt <= w_fmt;
               r_sk_tgt <= w_tgt;
               r_rdy    <= 1'b0;
               r_st     <= TWO;
            end else if (w_otx) begin
               r_vld <= 1'b0;
               r_st  <= EMPTY;
            end
            TWO: if (w_otx) begin
               r_imm <= r_sk_imm;
               r_fmt <= r_sk_fmt;
               r_tgt <= r_sk_tgt;
               r_rdy <= 1'b1;
               r_st  <= ONE;
            end
            default: r_st <= EMPTY;
         endcase
      end
   end
endmodule

// File: tb/tb_imm_gen_pipe.sv
// tb_imm_gen_pipe: queue-model checker for imm_gen_pipe at XLEN=32/CNT_W=16 and XLEN=64/CNT_W=2.
module tb_imm_gen_pipe;
   logic        clk = 0, rst = 1, in_valid = 0, out_ready = 1;
   logic [31:0] instr = 0;
   logic [63:0] pc = 0;
   logic        rdy32, vld32, ill32, rdy64, vld64, ill64;
   logic [31:0] imm32, tgt32;
   logic [63:0] imm64, tgt64;
   logic [2:0]  fmt32, fmt64;
   logic [15:0] c32;
   logic [1:0]  c64;
   int          ncmp = 0, nerr = 0;
   bit          armed = 0;
   always #5 clk = ~clk;

   imm_gen_pipe #(.XLEN(32), .CNT_W(16)) u32 (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(rdy32), .in_instr(instr),
      .in_pc(pc[31:0]), .out_valid(vld32), .out_ready(out_ready), .out_imm(imm32),
      .out_fmt(fmt32), .out_target(tgt32), .out_illegal(ill32), .illegal_cnt(c32));
   imm_gen_pipe #(.XLEN(64), .CNT_W(2)) u64 (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(rdy64), .in_instr(instr),
      .in_pc(pc), .out_valid(vld64), .out_ready(out_ready), .out_imm(imm64),
      .out_fmt(fmt64), .out_target(tgt64), .out_illegal(ill64), .illegal_cnt(c64));

   typedef struct packed {logic [2:0] f; logic [63:0] im; logic [63:0] pc;} ent_t;
   ent_t mq[$];
   int   mc32 = 0, mc64 = 0;

   function automatic void dec(input logic [31:0] ins, output logic [2:0] f, output logic [63:0] im);
      logic signed [63:0] s;
      s = $signed(ins);
      case (ins[6:0])
         7'h13, 7'h03, 7'h67, 7'h0F, 7'h73: f = 1;
         7'h23: f = 2;
         7'h63: f = 3;
         7'h37, 7'h17: f = 4;
         7'h6F: f = 5;
         7'h33: f = 0;
         default: f = 7;
      endcase
`ifdef IMM_GEN_ZIMM_EN
      if (ins[6:0] == 7'h73 && ins[14]) f = 6;
`endif
      case (f)
         1: im = s >>> 20;
         2: im = ((s >>> 25) << 5) | 64'(ins[11:7]);
         3: im = ((s >>> 31) << 12) | (64'(ins[7]) << 11) | (64'(ins[30:25]) << 5) | (64'(ins[11:8]) << 1);
         4: im = s & ~64'hFFF;
         5: im = ((s >>> 31) << 20) | (64'(ins[19:12]) << 12) | (64'(ins[20]) << 11) | (64'(ins[30:21]) << 1);
         6: im = 64'(ins[19:15]);
         default: im = 0;
      endcase
   endfunction

   task automatic chk(input string n, input logic [63:0] a, input logic [63:0] e);
      ncmp++;
      if (a !== e) begin
         nerr++;
         $display("FAIL %s: got %h expected %h", n, a, e);
      end
   endtask

   // model: a two-deep FIFO of decoded entries
   initial forever begin
      @(posedge clk);
      if (rst) begin
         mq.delete();
         mc32 = 0;
         mc64 = 0;
      end else begin
         bit acc;
         ent_t e;
         acc = in_valid && mq.size() < 2;
         if (mq.size() > 0 && out_ready) void'(mq.pop_front());
         if (acc) begin
            dec(instr, e.f, e.im);
            e.pc = pc;
            mq.push_back(e);
            if (e.f == 7 && mc32 < 65535) mc32++;
            if (e.f == 7 && mc64 < 3) mc64++;
         end
      end
   end

   initial forever begin
      @(negedge clk);
      if (armed) begin
         chk("rdy32", 64'(rdy32), 64'(mq.size() < 2));
         chk("rdy64", 64'(rdy64), 64'(mq.size() < 2));
         chk("vld32", 64'(vld32), 64'(mq.size() > 0));
         chk("vld64", 64'(vld64), 64'(mq.size() > 0));
         chk("cnt32", 64'(c32), 64'(mc32));
         chk("cnt64", 64'(c64), 64'(mc64));
         if (mq.size() > 0) begin
            logic [63:0] t;
            t = mq[0].pc + mq[0].im;
            chk("imm32", 64'(imm32), 64'(mq[0].im[31:0]));
            chk("tgt32", 64'(tgt32), 64'(t[31:0]));
            chk("fmt32", 64'(fmt32), 64'(mq[0].f));
            chk("ill32", 64'(ill32), 64'(mq[0].f == 7));
            chk("imm64", imm64, mq[0].im);
            chk("tgt64", tgt64, t);
            chk("fmt64", 64'(fmt64), 64'(mq[0].f));
            chk("ill64", 64'(ill64), 64'(mq[0].f == 7));
         end
      end
   end

   task automatic step();
      @(posedge clk);
      #2;
   endtask

   task automatic push(input logic [31:0] i, input logic [63:0] p);
      bit ok;
      instr = i;
      pc = p;
      in_valid = 1;
      for (int k = 0; k < 20; k++) begin
         ok = mq.size() < 2;
         step();
         if (ok) break;
      end
   endtask

   task automatic idle();
      in_valid = 0;
      step();
   endtask

   initial begin
      step();
      step();
      rst = 0;
      armed = 1;
      #1;
      chk("rst_vld", 64'(vld32), 0);
      chk("rst_rdy", 64'(rdy32), 1);
      chk("rst_imm", 64'(imm32), 0);
      chk("rst_fmt", 64'(fmt32), 0);
      chk("rst_tgt", 64'(tgt32), 0);
      chk("rst_ill", 64'(ill32), 0);
      chk("rst_cnt", 64'(c32), 0);
      // pipelined stream
      push(32'h00500093, 64'h100);
      chk("t1a_imm", 64'(imm32), 64'h5);
      chk("t1a_fmt", 64'(fmt32), 1);
      chk("t1a_tgt", 64'(tgt32), 64'h105);
      push(32'h00A12023, 64'h100);
      chk("t1b_imm", 64'(imm32), 0);
      chk("t1b_fmt", 64'(fmt32), 2);
      push(32'h00208663, 64'h100);
      chk("t1c_imm", 64'(imm32), 64'hC);
      chk("t1c_fmt", 64'(fmt32), 3);
      chk("t1c_tgt", 64'(tgt32), 64'h10C);
      push(32'h004000EF, 64'h100);
      chk("t1d_imm", 64'(imm32), 64'h4);
      chk("t1d_fmt", 64'(fmt32), 5);
      chk("t1d_tgt", 64'(tgt32), 64'h104);
      // sign extension
      push(32'hFFF00093, 64'h0);
      chk("t2a_imm32", 64'(imm32), 64'hFFFFFFFF);
      chk("t2a_tgt32", 64'(tgt32), 64'hFFFFFFFF);
      chk("t2a_imm64", imm64, 64'hFFFFFFFFFFFFFFFF);
      push(32'h800000B7, 64'h0);
      chk("t2b_imm64", imm64, 64'hFFFFFFFF80000000);
      chk("t2b_fmt", 64'(fmt64), 4);
      push(32'h40000033, 64'h40);
      chk("t2c_rimm", imm64, 0);
      chk("t2c_rfmt", 64'(fmt64), 0);
      idle();
      idle();
      // back-pressure
      out_ready = 0;
      push(32'h00100093, 64'h200);
      push(32'h00200093, 64'h200);
      instr = 32'h00300093;
      step();
      chk("t3_rdy_low", 64'(rdy32), 0);
      chk("t3_hold_a", 64'(imm32), 1);
      step();
      chk("t3_hold_b", 64'(imm32), 1);
      out_ready = 1;
      push(32'h00300093, 64'h200);
      chk("t3_last", 64'(imm32), 3);
      idle();
      idle();
      chk("t3_drained", 64'(vld32), 0);
      // illegal opcodes and counter saturation
      push(32'h0000007F, 64'h300);
      chk("t4_fmt", 64'(fmt32), 7);
      chk("t4_ill", 64'(ill32), 1);
      chk("t4_imm", 64'(imm32), 0);
      chk("t4_cnt", 64'(c32), 1);
      for (int k = 0; k < 4; k++) push(32'h0000007F, 64'h300);
      chk("t4_cnt32_5", 64'(c32), 5);
      chk("t4_cnt64_sat", 64'(c64), 3);
      idle();
      // reset while full
      out_ready = 0;
      push(32'h00700093, 64'h400);
      push(32'h00800093, 64'h400);
      in_valid = 0;
      chk("t5_two", 64'(rdy32), 0);
      rst = 1;
      instr = 32'h00900093;
      in_valid = 1;
      step();
      rst = 0;
      in_valid = 0;
      chk("t5_vld", 64'(vld32), 0);
      chk("t5_rdy", 64'(rdy32), 1);
      chk("t5_cnt", 64'(c32), 0);
      chk("t5_imm", 64'(imm32), 0);
      out_ready = 1;
      step();
      step();
      chk("t5_no_emit", 64'(vld64), 0);
      // CSR immediate form
      push(32'h0002D073, 64'h0);
`ifdef IMM_GEN_ZIMM_EN
      chk("t6_fmt", 64'(fmt32), 6);
      chk("t6_imm", 64'(imm32), 5);
`else
      chk("t6_fmt", 64'(fmt32), 1);
      chk("t6_imm", 64'(imm32), 0);
`endif
      idle();
      idle();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
      $finish;
   end
endmodule
